inequality_flag_tracker: RTL
============================

// Module: inequality_flag_tracker
// PURPOSE
//   Downstream stage of the 4-bit Inequality comparator. Samples its OUT[2:0]
//   flag vector each enabled cycle and filters glitches: a new vector is
//   committed only after STABLE_CYCLES consecutive identical samples.
//   Emits a one-cycle change pulse on each commit and keeps a saturating
//   per-flag count of committed 0->1 transitions for status/readback logic.
// PARAMETERS
//   WIDTH          3   flag vector width (matches comparator OUT)
//   STABLE_CYCLES  4   consecutive equal samples required to commit (>=2)
//   CNT_WIDTH      8   width of each per-flag rising-edge counter
// PORTS
//   CLK        in   1                clock, all logic on rising edge
//   RST        in   1                synchronous reset, active-high
//   EN         in   1                sample enable; FLAGS sampled only when 1
//   FLAGS      in   WIDTH            comparator flag vector (Inequality OUT)
//   CLR        in   1                sync clear of counters and ANY_SAT only
//   STABLE_OUT out  WIDTH            last committed (debounced) flag vector
//   CHG        out  1                1-cycle pulse when STABLE_OUT changes
//   RISE_CNT   out  WIDTH*CNT_WIDTH  packed counters; bit i at [i*CNT_WIDTH +: CNT_WIDTH]
//   ANY_SAT    out  1                1 while any counter is at 2^CNT_WIDTH-1
// BEHAVIOUR
//   Reset (RST=1 at an edge, overrides everything): STATE=STABLE,
//     STABLE_OUT=0, CHG=0, all RISE_CNT=0, ANY_SAT=0, cand=0, run=0.
//   Internal: cand[WIDTH-1:0] candidate vector; run counter,
//     $clog2(STABLE_CYCLES+1) bits. All outputs registered.
//   EN=0: no sample; state, cand, run, STABLE_OUT hold; CHG=0.
//   FSM, evaluated only on edges with EN=1:
//     STABLE: FLAGS==STABLE_OUT -> stay. Else -> SETTLE, cand=FLAGS, run=1.
//     SETTLE: FLAGS==STABLE_OUT -> STABLE, run=0 (glitch rejected, no CHG).
//             FLAGS!=cand (and !=STABLE_OUT) -> cand=FLAGS, run=1, stay.
//             FLAGS==cand, run+1<STABLE_CYCLES -> run=run+1, stay.
//             FLAGS==cand, run+1==STABLE_CYCLES -> commit: STABLE_OUT=cand,
//               CHG=1 for exactly the cycle after that edge, -> STABLE.
//   Latency: commit happens on the edge sampling the STABLE_CYCLES-th
//     consecutive equal EN-high sample; new STABLE_OUT and CHG are visible
//     immediately after that edge.
//   Counters: on commit, for each bit i with old STABLE_OUT[i]=0 and new=1,
//     RISE_CNT[i] increments; saturates at 2^CNT_WIDTH-1 (never wraps).
//     1->0 transitions are not counted.
//   ANY_SAT registered: reflects counter values after the same edge.
//   CLR=1: counters=0 and ANY_SAT=0 at that edge; CLR beats a same-edge
//     increment (result 0). CLR does not affect FSM, STABLE_OUT or CHG.
//   RST mid-SETTLE: pending candidate discarded, no CHG, reset values above.
// TESTING (STABLE_CYCLES=4 unless noted)
//   1 RST high 2 cycles, FLAGS=3'b111 -> STABLE_OUT=000, CHG=0, RISE_CNT=0,
//     ANY_SAT=0; after release with EN=0 outputs unchanged.
//   2 EN=1, FLAGS=101 held -> STABLE_OUT=000 after edges 1-3, 101 after edge 4;
//     CHG high one cycle; RISE_CNT[0]=1, [1]=0, [2]=1.
//   3 From stable 101: FLAGS=111 for 2 samples, then 101 -> STABLE_OUT stays
//     101, CHG never asserts, counters unchanged; FLAGS=000 (Inequality
//     output for NUM=2) held 4 samples -> commit 000, CHG pulse, no count.
//   4 FLAGS=010 x2 then 011 x4 -> no commit before 4th 011 sample; then
//     STABLE_OUT=011, CHG pulse, RISE_CNT[0] and [1] each +1.
//   5 FLAGS=110, EN alternating 1/0 -> commit after 4th EN-high sample
//     (8 cycles); EN=0 cycles never advance run.
//   6 CNT_WIDTH=2: commit 000/001 alternately 4 rising times -> RISE_CNT[0]=3
//     (held), ANY_SAT=1; CLR pulse -> 0, ANY_SAT=0; CLR on a commit edge
//     with bit0 rising -> RISE_CNT[0]=0, CHG still pulses.

Source files
------------

// File: rtl/inequality_flag_tracker.sv
// Glitch filter for the inequality comparator flag vector: commits a new vector after
// STABLE_CYCLES identical enabled samples and counts committed 0->1 transitions per flag.
module inequality_flag_tracker #(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic [WIDTH-1:0]           FLAGS,
    input  logic                       CLR,
    output logic [WIDTH-1:0]           STABLE_OUT,
    output logic                       CHG,
    output logic [WIDTH*CNT_WIDTH-1:0] RISE_CNT,
    output logic                       ANY_SAT
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    logic [0:0]               state, state_nxt;
    logic [WIDTH-1:0]         cand, cand_nxt;
    logic [RUN_W-1:0]         run, run_nxt;
    logic                     commit;
    logic [WIDTH-1:0]         rising;
    logic [WIDTH*CNT_WIDTH-1:0] cnt_nxt;
    logic                     sat_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        run_nxt   = run;
        commit    = 1'b0;
        if (EN) begin
            case (state)
                ST_STABLE: begin
                    if (FLAGS != STABLE_OUT) begin
                        state_nxt = ST_SETTLE;
                        cand_nxt  = FLAGS;
                        run_nxt   = RUN_W'(1);
                    end
                end
                ST_SETTLE: begin
                    // Returning to the committed value rejects the excursion as a glitch.
                    if (FLAGS == STABLE_OUT) begin
                        state_nxt = ST_STABLE;
                        run_nxt   = '0;
                    end else if (FLAGS != cand) begin
                        cand_nxt = FLAGS;
                        run_nxt  = RUN_W'(1);
                    end else if (run == RUN_LAST) begin
                        commit    = 1'b1;
                        state_nxt = ST_STABLE;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_STABLE;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    assign rising = cand & ~STABLE_OUT;

    // Clear wins over a same-edge increment; ANY_SAT tracks the post-edge counter values.
    always_comb begin
        cnt_nxt = RISE_CNT;
        sat_nxt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (CLR)
                cnt_nxt[i*CNT_WIDTH +: CNT_WIDTH] = '0;
            else if (commit && rising[i])
                cnt_nxt[i*CNT_WIDTH +: CNT_WIDTH] = sat_inc(RISE_CNT[i*CNT_WIDTH +: CNT_WIDTH]);
            if (cnt_nxt[i*CNT_WIDTH +: CNT_WIDTH] == CNT_MAX)
                sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_STABLE;
            cand       <= '0;
            run        <= '0;
            STABLE_OUT <= '0;
            CHG        <= 1'b0;
            RISE_CNT   <= '0;
            ANY_SAT    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            run      <= run_nxt;
            CHG      <= commit;
            RISE_CNT <= cnt_nxt;
            ANY_SAT  <= sat_nxt;
            if (commit)
                STABLE_OUT <= cand;
        end
    end

endmodule
